// File: rtl/ifetch_unit.sv
// Instruction fetch unit: gathers a variable-length instruction (1..10 bytes)
// through a narrow request/ack memory port, decodes it and presents it to a
// valid/ready consumer. Fault conditions (ADR/INS/HLT) park the unit in HALTED.
module ifetch_unit #(
  parameter int IMEM_DEPTH  = 1024,
  parameter int FETCH_BYTES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              pc_in,
  input  logic                     pc_load,
  output logic                     imem_req,
  output logic [63:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [8*FETCH_BYTES-1:0] imem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               icode,
  output logic [3:0]               ifun,
  output logic [3:0]               rA,
  output logic [3:0]               rB,
  output logic [63:0]              valC,
  output logic [63:0]              valP,
  output logic [63:0]              pc_out,
  output logic [2:0]               stat
);

  localparam logic [2:0] S_REQ     = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_PRESENT = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_HALTED  = 3'd4;

  localparam logic [2:0] STAT_AOK = 3'b001;
  localparam logic [2:0] STAT_HLT = 3'b010;
  localparam logic [2:0] STAT_ADR = 3'b011;
  localparam logic [2:0] STAT_INS = 3'b100;

  localparam logic [63:0] DEPTH64 = 64'(IMEM_DEPTH);

  logic [2:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [79:0] buf_q, buf_d;
  logic        req_q, req_d;
  logic [63:0] addr_q, addr_d;
  logic        ov_q, ov_d;
  logic [3:0]  icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
  logic [63:0] valc_q, valc_d, valp_q, valp_d, pcout_q, pcout_d;
  logic [2:0]  stat_q, stat_d;

  // Decode view of the buffer as it will look after the current ack
  logic [79:0] merged;
  logic [4:0]  sum5;
  logic [3:0]  cnt_acc;
  logic [3:0]  d_icode, d_ifun, d_len, d_ra, d_rb;
  logic        d_bad, d_adr;
  logic [63:0] d_valc, d_valp, d_last;

  // Instruction length from icode; unknown icodes count as one byte
  function automatic logic [3:0] insn_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:             insn_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:       insn_len = 4'd2;
      4'h7, 4'h8:                   insn_len = 4'd9;
      4'h3, 4'h4, 4'h5:             insn_len = 4'd10;
      default:                      insn_len = 4'd1;
    endcase
  endfunction

  // Illegal icode or illegal function code for a legal icode
  function automatic logic insn_bad(input logic [3:0] ic, input logic [3:0] fn);
    case (ic)
      4'h2, 4'h7:                               insn_bad = (fn > 4'd6);
      4'h6:                                     insn_bad = (fn > 4'd3);
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8,
      4'h9, 4'hA, 4'hB:                         insn_bad = (fn != 4'd0);
      default:                                  insn_bad = 1'b1;
    endcase
  endfunction

  // Merge ack bytes at the current offset and decode the result
  always_comb begin
    merged = buf_q;
    for (int k = 0; k < FETCH_BYTES; k++) begin
      if (int'(cnt_q) + k < 10) merged[(int'(cnt_q) + k)*8 +: 8] = imem_rdata[k*8 +: 8];
    end
    sum5    = {1'b0, cnt_q} + 5'(FETCH_BYTES);
    cnt_acc = (sum5 >= 5'd10) ? 4'd10 : sum5[3:0];
    d_icode = merged[7:4];
    d_ifun  = merged[3:0];
    d_len   = insn_len(d_icode);
    d_bad   = insn_bad(d_icode, d_ifun);
    if (d_len == 4'd2 || d_len == 4'd10) begin
      d_ra = merged[15:12];
      d_rb = merged[11:8];
    end else begin
      d_ra = 4'hF;
      d_rb = 4'hF;
    end
    case (d_icode)
      4'h3, 4'h4, 4'h5: d_valc = merged[79:16];
      4'h7, 4'h8:       d_valc = merged[71:8];
      default:          d_valc = 64'd0;
    endcase
    d_valp = pc_q + {60'd0, d_len};
    d_last = d_valp - 64'd1;
    d_adr  = (d_last >= DEPTH64);
  end

  // Fetch sequencing: redirect first, then per-state handling
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    req_d   = req_q;
    addr_d  = addr_q;
    ov_d    = ov_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    valc_d  = valc_q;
    valp_d  = valp_q;
    pcout_d = pcout_q;
    stat_d  = stat_q;
    if (pc_load) begin
      pc_d  = pc_in;
      cnt_d = 4'd0;
      ov_d  = 1'b0;
      if (req_q && !imem_ack) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_REQ;
        req_d   = 1'b0;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (pc_q >= DEPTH64) begin
            icode_d = 4'd0;
            ifun_d  = 4'd0;
            ra_d    = 4'hF;
            rb_d    = 4'hF;
            valc_d  = 64'd0;
            valp_d  = pc_q;
            pcout_d = pc_q;
            stat_d  = STAT_ADR;
            ov_d    = 1'b1;
            state_d = S_PRESENT;
          end else begin
            req_d   = 1'b1;
            addr_d  = pc_q + {60'd0, cnt_q};
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            buf_d = merged;
            cnt_d = cnt_acc;
            req_d = 1'b0;
            if (d_bad || d_adr || cnt_acc >= d_len) begin
              icode_d = d_icode;
              ifun_d  = d_ifun;
              ra_d    = d_ra;
              rb_d    = d_rb;
              valc_d  = d_valc;
              valp_d  = d_valp;
              pcout_d = pc_q;
              if (d_bad)                 stat_d = STAT_INS;
              else if (d_adr)            stat_d = STAT_ADR;
              else if (d_icode == 4'h0)  stat_d = STAT_HLT;
              else                       stat_d = STAT_AOK;
              ov_d    = 1'b1;
              state_d = S_PRESENT;
            end else begin
              state_d = S_REQ;
            end
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            ov_d = 1'b0;
            if (stat_q == STAT_AOK) begin
              pc_d    = valp_q;
              cnt_d   = 4'd0;
              state_d = S_REQ;
            end else begin
              state_d = S_HALTED;
            end
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = S_REQ;
          end
        end
        S_HALTED: begin
          state_d = S_HALTED;
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  // Control and presented-instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= 64'd0;
      cnt_q   <= 4'd0;
      req_q   <= 1'b0;
      addr_q  <= 64'd0;
      ov_q    <= 1'b0;
      icode_q <= 4'd0;
      ifun_q  <= 4'd0;
      ra_q    <= 4'd0;
      rb_q    <= 4'd0;
      valc_q  <= 64'd0;
      valp_q  <= 64'd0;
      pcout_q <= 64'd0;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ov_q    <= ov_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      valc_q  <= valc_d;
      valp_q  <= valp_d;
      pcout_q <= pcout_d;
      stat_q  <= stat_d;
    end
  end

  // Assembly buffer contents are only meaningful below cnt_q
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign out_valid = ov_q;
  assign icode     = icode_q;
  assign ifun      = ifun_q;
  assign rA        = ra_q;
  assign rB        = rb_q;
  assign valC      = valc_q;
  assign valP      = valp_q;
  assign pc_out    = pcout_q;
  assign stat      = stat_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: instance a uses the default depth,
// instance b uses a 16-byte memory for the boundary case.
module tb_ifetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pc_load, out_ready;
  logic [63:0] pc_in;

  logic        imem_req_a, imem_ack_a, out_valid_a;
  logic [63:0] imem_addr_a, valc_a, valp_a, pc_out_a;
  logic [15:0] imem_rdata_a;
  logic [3:0]  icode_a, ifun_a, ra_a, rb_a;
  logic [2:0]  stat_a;

  logic        imem_req_b, imem_ack_b, out_valid_b;
  logic [63:0] imem_addr_b, valc_b, valp_b, pc_out_b;
  logic [15:0] imem_rdata_b;
  logic [3:0]  icode_b, ifun_b, ra_b, rb_b;
  logic [2:0]  stat_b;

  logic [7:0] mem [0:1023];
  int checks = 0;
  int failures = 0;
  int age_a, age_b, acc_a, acc_b;
  bit hi_b;

  ifetch_unit #(.IMEM_DEPTH(1024), .FETCH_BYTES(2)) dut_a (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_load(pc_load),
    .imem_req(imem_req_a), .imem_addr(imem_addr_a), .imem_ack(imem_ack_a),
    .imem_rdata(imem_rdata_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .icode(icode_a), .ifun(ifun_a), .rA(ra_a), .rB(rb_a),
    .valC(valc_a), .valP(valp_a), .pc_out(pc_out_a), .stat(stat_a));

  ifetch_unit #(.IMEM_DEPTH(16), .FETCH_BYTES(2)) dut_b (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_load(pc_load),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_ack_b),
    .imem_rdata(imem_rdata_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .icode(icode_b), .ifun(ifun_b), .rA(ra_b), .rB(rb_b),
    .valC(valc_b), .valP(valp_b), .pc_out(pc_out_b), .stat(stat_b));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; memory answers in the second cycle of each request
  task automatic tick();
    int a;
    @(posedge clk); #1;
    if (imem_ack_a) begin
      imem_ack_a = 1'b0; age_a = 0;
    end else if (imem_req_a) begin
      age_a++;
      if (age_a > 1) begin
        a = int'(imem_addr_a[9:0]);
        imem_rdata_a = {mem[(a+1)%1024], mem[a]};
        imem_ack_a = 1'b1; acc_a++;
      end
    end
    if (imem_req_b && imem_addr_b >= 64'd12) hi_b = 1'b1;
    if (imem_ack_b) begin
      imem_ack_b = 1'b0; age_b = 0;
    end else if (imem_req_b) begin
      age_b++;
      if (age_b > 1) begin
        a = int'(imem_addr_b[9:0]);
        imem_rdata_b = {mem[(a+1)%1024], mem[a]};
        imem_ack_b = 1'b1; acc_b++;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1; pc_load = 1'b0; out_ready = 1'b0; pc_in = 64'd0;
    imem_ack_a = 1'b0; imem_ack_b = 1'b0; imem_rdata_a = 16'd0; imem_rdata_b = 16'd0;
    age_a = 0; age_b = 0; acc_a = 0; acc_b = 0; hi_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_va(input string tag);
    int n = 0;
    while (!out_valid_a && n < 60) begin tick(); n++; end
    chk(tag, {63'd0, out_valid_a}, 64'd1);
  endtask

  logic [7:0] bad_bytes [0:2];
  logic [2:0] bad_stat  [0:2];
  logic [63:0] bad_valp [0:2];

  initial begin
    int n;
    clear_mem();
    rst = 1'b1; pc_load = 1'b0; out_ready = 1'b0; pc_in = 64'd0;
    imem_ack_a = 1'b0; imem_ack_b = 1'b0; imem_rdata_a = 16'd0; imem_rdata_b = 16'd0;
    #2;
    chk("rst_req", {63'd0, imem_req_a}, 64'd0);
    chk("rst_addr", imem_addr_a, 64'd0);
    chk("rst_valid", {63'd0, out_valid_a}, 64'd0);
    chk("rst_icode", {60'd0, icode_a}, 64'd0);
    chk("rst_ra", {60'd0, ra_a}, 64'd0);
    chk("rst_valp", valp_a, 64'd0);
    chk("rst_pcout", pc_out_a, 64'd0);
    chk("rst_stat", {61'd0, stat_a}, 64'd1);

    // 10-byte instruction: irmovq-style, five 2-byte accesses
    clear_mem();
    {mem[0], mem[1], mem[2], mem[3], mem[4]} = {8'h30, 8'hF3, 8'h08, 8'h07, 8'h06};
    {mem[5], mem[6], mem[7], mem[8], mem[9]} = {8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    do_reset();
    tick();
    chk("first_req", {63'd0, imem_req_a}, 64'd1);
    chk("first_addr", imem_addr_a, 64'd0);
    wait_va("long_valid");
    chk("long_acc", acc_a, 64'd5);
    chk("long_icode", {60'd0, icode_a}, 64'd3);
    chk("long_ifun", {60'd0, ifun_a}, 64'd0);
    chk("long_ra", {60'd0, ra_a}, 64'hF);
    chk("long_rb", {60'd0, rb_a}, 64'h3);
    chk("long_valc", valc_a, 64'h0102030405060708);
    chk("long_valp", valp_a, 64'd10);
    chk("long_stat", {61'd0, stat_a}, 64'd1);

    // 1-byte nop held under backpressure, then next fetch at 1
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h10;
    do_reset();
    wait_va("nop_valid");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", {63'd0, out_valid_a}, 64'd1);
      chk("hold_icode", {60'd0, icode_a}, 64'd1);
      chk("hold_valp", valp_a, 64'd1);
      chk("hold_ra", {60'd0, ra_a}, 64'hF);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("accept_valid", {63'd0, out_valid_a}, 64'd0);
    tick();
    chk("next_req", {63'd0, imem_req_a}, 64'd1);
    chk("next_addr", imem_addr_a, 64'd1);
    chk("next_valid", {63'd0, out_valid_a}, 64'd0);

    // Fault stats, each followed by HALTED
    bad_bytes[0] = 8'hC0; bad_stat[0] = 3'b100; bad_valp[0] = 64'd1;
    bad_bytes[1] = 8'h27; bad_stat[1] = 3'b100; bad_valp[1] = 64'd2;
    bad_bytes[2] = 8'h00; bad_stat[2] = 3'b010; bad_valp[2] = 64'd1;
    for (int t = 0; t < 3; t++) begin
      clear_mem();
      mem[0] = bad_bytes[t];
      do_reset();
      wait_va("bad_valid");
      chk("bad_stat", {61'd0, stat_a}, {61'd0, bad_stat[t]});
      chk("bad_valp", valp_a, bad_valp[t]);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      repeat (3) tick();
      chk("halt_valid", {63'd0, out_valid_a}, 64'd0);
      chk("halt_req", {63'd0, imem_req_a}, 64'd0);
      chk("halt_stat", {61'd0, stat_a}, {61'd0, bad_stat[t]});
    end

    // Small memory: 9-byte instruction at 10 overruns 16 bytes
    clear_mem();
    mem[10] = 8'h70;
    do_reset();
    pc_in = 64'd10; pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    n = 0;
    while (!out_valid_b && n < 40) begin tick(); n++; end
    chk("adr_valid", {63'd0, out_valid_b}, 64'd1);
    chk("adr_stat", {61'd0, stat_b}, 64'd3);
    chk("adr_acc", acc_b, 64'd1);
    chk("adr_pcout", pc_out_b, 64'd10);
    repeat (4) tick();
    chk("adr_no_high", {63'd0, hi_b}, 64'd0);

    // Redirect with a request outstanding: old data dropped
    clear_mem();
    mem[0] = 8'h00; mem[1] = 8'h00; mem[32] = 8'h10;
    do_reset();
    tick();
    chk("drain_req0", {63'd0, imem_req_a}, 64'd1);
    pc_in = 64'h20; pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    chk("drain_hold_req", {63'd0, imem_req_a}, 64'd1);
    chk("drain_hold_addr", imem_addr_a, 64'd0);
    tick();
    tick();
    chk("redir_req", {63'd0, imem_req_a}, 64'd1);
    chk("redir_addr", imem_addr_a, 64'h20);
    wait_va("redir_valid");
    chk("redir_icode", {60'd0, icode_a}, 64'd1);
    chk("redir_pcout", pc_out_a, 64'h20);
    chk("redir_valp", valp_a, 64'h21);
    chk("redir_stat", {61'd0, stat_a}, 64'd1);

    // Asynchronous reset in the middle of a multi-access fetch
    clear_mem();
    {mem[0], mem[1], mem[2], mem[3]} = {8'h30, 8'hF3, 8'h08, 8'h07};
    do_reset();
    n = 0;
    while (acc_a < 1 && n < 20) begin tick(); n++; end
    tick();
    tick();
    chk("mid_req", {63'd0, imem_req_a}, 64'd1);
    chk("mid_addr", imem_addr_a, 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {63'd0, imem_req_a}, 64'd0);
    chk("arst_addr", imem_addr_a, 64'd0);
    chk("arst_valid", {63'd0, out_valid_a}, 64'd0);
    chk("arst_stat", {61'd0, stat_a}, 64'd1);
    mem[0] = 8'h10;
    do_reset();
    wait_va("fresh_valid");
    chk("fresh_icode", {60'd0, icode_a}, 64'd1);
    chk("fresh_pcout", pc_out_a, 64'd0);
    chk("fresh_valp", valp_a, 64'd1);
    chk("fresh_acc", acc_a, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 1024: instruction-memory size in bytes, addresses 0..IMEM_DEPTH-1.
REQ-002 SHALL have parameter FETCH_BYTES, default 2: bytes returned per memory access, legal values 1, 2, 4, 8.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port pc_in, input, 64: redirect target PC.
REQ-006 SHALL have port pc_load, input, 1: load pc_in as the new fetch PC.
REQ-007 SHALL have port imem_req, output, 1: memory read request.
REQ-008 SHALL have port imem_addr, output, 64: byte address of the request.
REQ-009 SHALL have port imem_ack, input, 1: imem_rdata is valid this cycle.
REQ-010 SHALL have port imem_rdata, input, 8*FETCH_BYTES: byte k of the access at bits [8k+7:8k], from address imem_addr+k.
REQ-011 SHALL have port out_valid, output, 1: fetched instruction fields are valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the instruction.
REQ-013 SHALL have ports icode, ifun, rA, rB, outputs, 4 each: decoded byte-0 and byte-1 fields.
REQ-014 SHALL have ports valC, valP, pc_out, outputs, 64 each: constant word, next PC, and PC of this instruction.
REQ-015 SHALL have port stat, output, 3: 001 AOK, 010 HLT, 011 ADR, 100 INS.

Function
REQ-016 SHALL use FSM states REQ, WAIT, PRESENT, DRAIN, HALTED.
REQ-017 SHALL hold at most one outstanding request; imem_req and imem_addr stay stable from assertion until imem_ack, which may arrive in the same cycle or any later cycle.
REQ-018 SHALL place each ack's bytes into a 10-byte assembly buffer at offset count, then advance count by FETCH_BYTES, saturating at 10.
REQ-019 SHALL decode byte 0 as icode = bits [7:4] and ifun = bits [3:0].
REQ-020 SHALL use instruction lengths: icode 0/1/9 -> 1 byte; 2/6/A/B -> 2; 7/8 -> 9; 3/4/5 -> 10; any other icode -> INS with length 1.
REQ-021 SHALL also flag INS when ifun > 6 for icode 2 or 7, when ifun > 3 for icode 6, or when ifun != 0 for any other icode.
REQ-022 SHALL decode byte 1 as rA = bits [7:4] and rB = bits [3:0] for 2-byte and 10-byte instructions, and drive rA = rB = F otherwise.
REQ-023 SHALL take valC little-endian from bytes 2..9 for icode 3/4/5, from bytes 1..8 for icode 7/8, and drive 0 otherwise.
REQ-024 SHALL compute valP = pc_out + length, with 64-bit wrap-around.
REQ-025 SHALL report ADR, without issuing any request, if PC >= IMEM_DEPTH.
REQ-026 SHALL report ADR, with no further requests, if PC+length-1 >= IMEM_DEPTH once length is known; bytes returned beyond the needed length are ignored.
REQ-027 SHALL assert out_valid the cycle after the ack that completes the instruction (or immediately after an ADR/INS decision), and hold all outputs stable while out_valid=1 and out_ready=0.
REQ-028 On acceptance with stat=AOK, SHALL set PC to valP and enter REQ the next cycle, deasserting out_valid.
REQ-029 On acceptance with stat HLT/ADR/INS, SHALL enter HALTED: no requests, out_valid=0, stat held at the last value.
REQ-030 SHALL give pc_load priority over all other events in every state: PC <= pc_in, count cleared, out_valid cleared.
REQ-031 If pc_load occurs with a request outstanding, SHALL enter DRAIN, discard the pending ack's data, then enter REQ.
REQ-032 SHALL leave HALTED only via pc_load or rst.

Reset
REQ-033 While rst=1: PC=0, count=0, state=REQ, imem_req=0, imem_addr=0, out_valid=0, icode=ifun=rA=rB=0, valC=valP=pc_out=0, stat=001.
REQ-034 SHALL issue the first request in the first clock after rst deasserts; rst asserted mid-fetch SHALL discard all partial state immediately.

Verification
REQ-035 With FETCH_BYTES=2 and memory 30 F3 08 07 06 05 04 03 02 01 at 0, ack one cycle after req -> 5 accesses; outputs icode=3, rA=F, rB=3, valC=0x0102030405060708, valP=10, stat=001.
REQ-036 Byte 10 at PC=0, out_ready=0 for 3 cycles -> out_valid and fields held stable for 3 cycles; on acceptance, a request at addr 1 with no further out_valid.
REQ-037 Byte 0xC0 -> stat=100, valP=1; byte 0x27 -> stat=100; byte 0x00 -> stat=010; each followed by HALTED.
REQ-038 IMEM_DEPTH=16 with 70 at PC=10 -> stat=011 after the first ack, with no access at address 12 or above.
REQ-039 pc_load with pc_in=0x20 while a request is outstanding -> the next ack's data is discarded; the next request address is 0x20.
REQ-040 rst pulse during WAIT -> all outputs at reset values asynchronously; a fresh fetch at PC 0 after release.
